fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of `core`. It owns the program counter, issues word reads to instruction memory, and buffers returned instructions in a small FIFO. It presents instructions to the decoder/core through a valid/ready handshake and accepts branch/jump redirects back from `core`.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, 2: instruction buffer entries; legal values are 2 or 4.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: one-cycle read request pulse to instruction memory.
- `imem_addr`  out  32: word address of the read; valid while `imem_req` is high.
- `imem_valid`  in  1: read data valid; arrives ≥1 cycle after the matching `imem_req`.
- `imem_rdata`  in  32: instruction word; qualified by `imem_valid`.
- `instr_valid`  out  1: FIFO head holds a valid instruction.
- `instr_ready`  in  1: consumer accepts the head this cycle.
- `instr`  out  32: head instruction.
- `instr_pc`  out  32: PC of the head instruction.
- `redirect`  in  1: branch/jump taken; flush and refetch.
- `redirect_pc`  in  32: new fetch PC; qualified by `redirect`.
- `fault`  out  1: sticky misaligned-redirect flag; see Configuration.

## Operation
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: one stale request outstanding; its response is discarded.
  - HALT: fault stop.
- At most one outstanding request at any time.
- REQ → WAIT when `imem_req` fires.
  - Issue condition: `count_next < DEPTH`, where `count_next = count + push − pop` for this cycle.
- WAIT, on `imem_valid`:
  - Push `{imem_rdata, pc}` into the FIFO and advance `pc += 4`.
  - If the issue condition holds with the new PC, issue the next request in the same cycle and stay in WAIT. Otherwise go to REQ.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
- Pop: `instr_valid && instr_ready` removes the head.
- `redirect` has the highest priority:
  - Flush the FIFO and set `pc = redirect_pc`.
  - Any same-cycle pop or push is cancelled.
  - No request issues in the redirect cycle.
  - If a request is outstanding and `imem_valid` is low this cycle → DROP. Otherwise → REQ.
- DROP:
  - `imem_valid` discards the data and moves to REQ.
  - A further `redirect` in DROP only updates `pc` and stays in DROP.
- FIFO full with a response arriving cannot occur, because the issue condition reserves a slot. An assertion covers this in simulation.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
  - `fault` = 0.
  - FIFO empty, state REQ, `pc` = `RESET_PC`.
- First request is in the first cycle after `reset` deasserts.
- Latency from request to consumer:
  - Request in cycle N, response in cycle N+1, `instr_valid` in cycle N+2.
- With 1-cycle memory and `instr_ready` held high, throughput is 1 instruction/cycle.
- `instr`/`instr_pc` are registered FIFO outputs. They are stable while `instr_valid && !instr_ready`.
- After a redirect in cycle R:
  - `instr_valid` = 0 in R+1.
  - From REQ, a request to `redirect_pc` issues in R+1.
  - From DROP, the request issues the cycle after the stale response.
- Reset asserted mid-operation: everything returns to reset values at the next edge. Any in-flight response is ignored in the cycle `reset` is high.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A `redirect` with `redirect_pc[1:0] != 0` sets `fault`, flushes the FIFO, and enters HALT.
  - In HALT, no requests issue until `reset`.
  - An outstanding response is discarded.
- `FETCH_ALIGN_CHECK_EN` not defined:
  - `redirect_pc[1:0]` is forced to 0.
  - `fault` is tied to 0 and HALT is unreachable.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (REQ, WAIT, DROP, HALT).
  - `WORD_W` = 32 and the `PC_STEP` = 4 constant.
  - Default `RESET_PC`.
  - `fetch_entry_t` struct holding `{instr, pc}`.
- One sub-module, `fetch_fifo`:
  - Synchronous FIFO parameterised by `DEPTH`.
  - Ports for push, pop, flush, count, and registered head.

## Test plan
- Reset release, memory replies 1 cycle later with 32'h2008_0005 at 0x0, 32'h2009_0003 at 0x4, `instr_ready` = 1 → requests to 0x0, 0x4, 0x8 on consecutive cycles; `instr_valid` from cycle 2 with `instr_pc` 0x0, 0x4.
- `instr_ready` = 0 → exactly `DEPTH` instructions buffered, `imem_req` stays 0, and head stays 0x0 until ready rises.
- Redirect to 0x40 in the same cycle as the response for 0x8 → data dropped, `instr_valid` = 0 next cycle, next request 0x40, and the first instruction delivered has `instr_pc` 0x40.
- Redirect to 0x80 while a 3-cycle-latency request is outstanding → DROP; stale response discarded; request 0x80 issues the following cycle.
- `RESET_PC` = 32'hFFFF_FFFC → second request address 32'h0000_0000.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x42 → `fault` = 1 next cycle, no further `imem_req`, and `reset` clears it. Without the macro, the request goes to 0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (request / wait / drop stale / halted on fault)
//   fetch_entry_t : one buffered instruction with the PC it was fetched from
//   WORD_W, PC_STEP, DEFAULT_RESET_PC : datapath width, PC increment, default boot PC
package fetch_pkg;

   localparam int unsigned WORD_W           = 32;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      StReq,
      StWait,
      StDrop,
      StHalt
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous instruction buffer (DEPTH must be a power of two, 2 or 4).
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears pointers and storage)
//   flush        : drop all entries this cycle (overrides push/pop)
//   push         : write push_data ({instr, pc}) at the tail
//   pop          : remove the head entry (caller guarantees non-empty)
//   count        : number of valid entries
//   head         : registered head entry ({instr, pc}); meaningful while count != 0
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  logic [2*WORD_W-1:0]            push_data,
   input  logic                           pop,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic [2*WORD_W-1:0]            head
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   rd_q, wr_q;
   logic [CW-1:0]   cnt_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PW'(1);
         if (pop)  rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Storage is cleared only by reset so the head reads zero out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push && !flush) begin
         mem_q[wr_q] <= fetch_entry_t'(push_data);
      end
   end

   assign count = cnt_q;
   assign head  = mem_q[rd_q];

   // The fetch issue rule always reserves a slot for an outstanding response.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
      !(push && !flush && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one word read at a time to
// instruction memory, buffers responses in fetch_fifo and hands them to the core over a
// valid/ready handshake. Branch/jump redirects flush the buffer and restart fetch.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   imem_req, imem_addr      : one-cycle read request and its word address
//   imem_valid, imem_rdata   : read response (>=1 cycle after the request)
//   instr_valid, instr_ready : head-of-buffer handshake to the core
//   instr, instr_pc          : head instruction and its PC
//   redirect, redirect_pc    : taken branch/jump and its target
//   fault                    : sticky misaligned-redirect flag
// Build option: FETCH_ALIGN_CHECK_EN - trap misaligned redirect targets (fault + halt);
// when undefined the target's low two bits are ignored and fault is always 0.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fault
);

   localparam int unsigned CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d, pc_inc;
   logic          fault_q, fault_d;

   logic          push, pop, flush;
   logic          push_cand, pop_cand;
   logic [CW-1:0] count;
   logic [CW:0]   count_next;
   logic          issue_ok;
   logic [2*WORD_W-1:0] head;

   logic          misaligned;
   logic [31:0]   redirect_pc_al;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned     = redirect_pc[1:0] != 2'b00;
   assign redirect_pc_al = redirect_pc;
`else
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign misaligned          = 1'b0;
   assign redirect_pc_al      = {redirect_pc[31:2], 2'b00};
`endif

   // Occupancy this cycle would leave if no redirect cancels the push/pop; a new
   // request is only allowed if that still leaves room for its response.
   assign push_cand  = (state_q == StWait) && imem_valid;
   assign pop_cand   = instr_valid && instr_ready;
   assign count_next = {1'b0, count} + (CW+1)'(push_cand) - (CW+1)'(pop_cand);
   assign issue_ok   = count_next < DEPTH_C;
   assign pc_inc     = pc_q + PC_STEP;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StReq;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fault_d   = fault_q;
      imem_req  = 1'b0;
      imem_addr = pc_q;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;

      if (redirect && state_q != StHalt) begin
         flush = 1'b1;
         if (misaligned) begin
            fault_d = 1'b1;
            state_d = StHalt;
         end else begin
            pc_d = redirect_pc_al;
            // A request still in flight must have its response swallowed.
            if ((state_q == StWait || state_q == StDrop) && !imem_valid) begin
               state_d = StDrop;
            end else begin
               state_d = StReq;
            end
         end
      end else begin
         pop = pop_cand;
         unique case (state_q)
            StReq: begin
               if (issue_ok) begin
                  imem_req = 1'b1;
                  state_d  = StWait;
               end
            end
            StWait: begin
               if (imem_valid) begin
                  push      = 1'b1;
                  pc_d      = pc_inc;
                  imem_addr = pc_inc;
                  if (issue_ok) begin
                     imem_req = 1'b1;
                  end else begin
                     state_d = StReq;
                  end
               end
            end
            StDrop: begin
               if (imem_valid) state_d = StReq;
            end
            StHalt: begin
            end
            default: state_d = StReq;
         endcase
      end

      if (reset) begin
         imem_req = 1'b0;
         push     = 1'b0;
         pop      = 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_data ({imem_rdata, pc_q}),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   assign instr_valid = count != '0;
   assign instr       = head[2*WORD_W-1:WORD_W];
   assign instr_pc    = head[WORD_W-1:0];
   assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (DEPTH = 2). A per-cycle vector table
// covers streaming, back-pressure and a redirect colliding with a response; hand-written
// sequences cover the stale-response drop, PC wrap-around and misaligned redirects.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr, instr_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fault;

   // Second instance for the PC wrap-around case.
   logic        req2;
   logic [31:0] addr2;
   logic        valid2 = 1'b0;
   logic [31:0] rdata2 = '0;
   logic        iv2, fault2;
   logic [31:0] instr2, ipc2;
   logic        req2_seen = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fault(fault)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req(req2), .imem_addr(addr2),
      .imem_valid(valid2), .imem_rdata(rdata2),
      .instr_valid(iv2), .instr_ready(1'b1),
      .instr(instr2), .instr_pc(ipc2),
      .redirect(1'b0), .redirect_pc(32'h0),
      .fault(fault2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h2008_0005;
      if (a == 32'h4) return 32'h2009_0003;
      return ~a;
   endfunction

   // Memory model: captures a request mid-cycle, answers 'lat' cycles later.
   int          cyc = 0;
   int          lat = 1;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          pend_due = 0;

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend && cyc == pend_due) begin
         imem_valid = 1'b1;
         imem_rdata = mem_word(pend_addr);
         pend       = 1'b0;
      end else begin
         imem_valid = 1'b0;
         imem_rdata = '0;
      end
      valid2 = req2_seen && !reset;
      rdata2 = 32'h5555_0000;
   end

   always begin
      @(negedge clk);
      req2_seen = req2;
      if (reset) begin
         pend = 1'b0;
      end else if (imem_req) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_due  = cyc + lat;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        ereq;
      logic [31:0] eaddr;
      logic        eiv;
      logic [31:0] epc;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic ready, input logic redir, input logic [31:0] rpc,
                               input logic ereq, input logic [31:0] eaddr,
                               input logic eiv, input logic [31:0] epc);
      vec_t v;
      v.ready = ready; v.redir = redir; v.rpc = rpc;
      v.ereq = ereq; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Cycle 0 is the first cycle after reset deasserts; memory latency 1.
      vecs[0]  = mk(1, 0, 0,     1, 32'h00, 0, 0);
      vecs[1]  = mk(1, 0, 0,     1, 32'h04, 0, 0);
      vecs[2]  = mk(1, 0, 0,     1, 32'h08, 1, 32'h00);
      vecs[3]  = mk(1, 0, 0,     1, 32'h0C, 1, 32'h04);
      vecs[4]  = mk(0, 0, 0,     0, 0,      1, 32'h08);  // second entry arrives: full
      vecs[5]  = mk(0, 0, 0,     0, 0,      1, 32'h08);
      vecs[6]  = mk(0, 0, 0,     0, 0,      1, 32'h08);
      vecs[7]  = mk(1, 0, 0,     1, 32'h10, 1, 32'h08);
      vecs[8]  = mk(1, 0, 0,     1, 32'h14, 1, 32'h0C);
      vecs[9]  = mk(1, 0, 0,     1, 32'h18, 1, 32'h10);
      vecs[10] = mk(1, 1, 32'h40, 0, 0,     1, 32'h14);  // redirect meets response for 0x18
      vecs[11] = mk(1, 0, 0,     1, 32'h40, 0, 0);
      vecs[12] = mk(1, 0, 0,     1, 32'h44, 0, 0);
      vecs[13] = mk(1, 0, 0,     1, 32'h48, 1, 32'h40);

      // ---- reset values
      reset = 1'b1;
      repeat (2) step();
      @(negedge clk);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_fault", 32'(fault), 32'd0);

      // ---- table: streaming, back-pressure, redirect colliding with a response
      lat = 1;
      foreach (vecs[i]) begin
         step();
         reset       = 1'b0;
         instr_ready = vecs[i].ready;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         @(negedge clk);
         check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].ereq));
         if (vecs[i].ereq) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].eaddr);
         check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].eiv));
         if (vecs[i].eiv) begin
            check($sformatf("v%0d_pc", i), instr_pc, vecs[i].epc);
            check($sformatf("v%0d_instr", i), instr, mem_word(vecs[i].epc));
         end
      end
      redirect = 1'b0;

      // ---- redirect with a slow request outstanding -> stale response dropped
      reset = 1'b1;
      lat   = 3;
      repeat (2) step();
      step();
      reset = 1'b0;                                // cycle 0: request to 0x0
      @(negedge clk);
      check("drop_c0_req", 32'(imem_req), 32'd1);
      check("wrap_c0_req", 32'(req2), 32'd1);
      check("wrap_c0_addr", addr2, 32'hFFFF_FFFC);
      step();
      redirect    = 1'b1;                          // cycle 1
      redirect_pc = 32'h80;
      @(negedge clk);
      check("drop_c1_req", 32'(imem_req), 32'd0);
      check("wrap_c1_req", 32'(req2), 32'd1);
      check("wrap_c1_addr", addr2, 32'h0000_0000);
      step();
      redirect = 1'b0;                             // cycle 2
      @(negedge clk);
      check("drop_c2_req", 32'(imem_req), 32'd0);
      check("wrap_c2_pc", ipc2, 32'hFFFF_FFFC);
      step();                                      // cycle 3: stale response
      @(negedge clk);
      check("drop_c3_stale_seen", 32'(imem_valid), 32'd1);
      check("drop_c3_req", 32'(imem_req), 32'd0);
      step();                                      // cycle 4
      @(negedge clk);
      check("drop_c4_req", 32'(imem_req), 32'd1);
      check("drop_c4_addr", imem_addr, 32'h80);
      check("drop_c4_valid", 32'(instr_valid), 32'd0);
      for (int k = 0; k < 10 && !instr_valid; k++) begin
         step();
         @(negedge clk);
      end
      check("drop_first_valid", 32'(instr_valid), 32'd1);
      check("drop_first_pc", instr_pc, 32'h80);
      check("drop_first_instr", instr, mem_word(32'h80));

      // ---- misaligned redirect
      reset = 1'b1;
      lat   = 1;
      repeat (2) step();
      step();
      reset       = 1'b0;                          // cycle 0: redirect, no issue
      redirect    = 1'b1;
      redirect_pc = 32'h42;
      @(negedge clk);
      check("align_c0_req", 32'(imem_req), 32'd0);
      step();
      redirect = 1'b0;
      @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
      check("align_fault", 32'(fault), 32'd1);
      check("align_halt_req", 32'(imem_req), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         check("align_halt_req", 32'(imem_req), 32'd0);
         check("align_fault_sticky", 32'(fault), 32'd1);
      end
      step();
      reset = 1'b1;
      @(negedge clk);
      check("align_reset_clears_fault", 32'(fault), 32'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("align_after_reset_req", 32'(imem_req), 32'd1);
      check("align_after_reset_addr", imem_addr, 32'h0);
`else
      check("align_fault_tied", 32'(fault), 32'd0);
      check("align_req", 32'(imem_req), 32'd1);
      check("align_addr", imem_addr, 32'h40);
      step();
      @(negedge clk);
      check("align_next_addr", imem_addr, 32'h44);
      step();
      @(negedge clk);
      check("align_pc", instr_pc, 32'h40);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
